// File: rtl/serial_add_acc.sv
// serial_add_acc: bit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per cycle, feeding a result accumulator.
// Latency: N = WIDTH/DIGIT cycles from accept to out_valid; one result per N+2 cycles when out_ready is held high.
// Backpressure: in_ready is high only in IDLE. The result and flags are held in DONE until out_ready, and no request is queued.
// Ports: clk/rst (async active-high); in_valid/in_ready request handshake with a, b, sub, acc_sel;
//        clr accumulator clear; out_valid/out_ready result handshake with sum, carry, overflow, zero.
module serial_add_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc_sel,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] acc;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic [WIDTH-1:0] res_next;

  // One DIGIT-wide ripple stage. dcmsb is the carry into the top bit of the digit.
  // On the final digit that bit is the operand MSB, so dcmsb ^ dcout gives the signed overflow.
  always_comb begin
    logic c;
    c     = cy;
    dsum  = '0;
    dcmsb = cy;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) dcmsb = c;
      dsum[i] = a_sh[i] ^ b_sh[i] ^ c;
      c       = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
    end
    dcout    = c;
    // Result digits enter at the MSB end, so after N shifts the LSB digit sits at bit 0.
    res_next = (res_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      acc      <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= acc_sel ? acc : a;
            // Subtraction is A + ~B + 1: the +1 enters through the initial carry.
            b_sh  <= sub ? ~b : b;
            cy    <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          cy     <= dcout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum      <= res_next;
            carry    <= dcout;
            overflow <= dcmsb ^ dcout;
            zero     <= (res_next == '0);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= sum;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a clear beats an accumulator load on the same edge.
      if (clr) acc <= '0;
    end
  end

endmodule

// File: doc/serial_add_acc.md
# serial_add_acc

Parametrised bit-serial adder/subtractor with an internal accumulator, the multi-bit, sequential successor to the team's single-bit half-adder datapath. It takes two WIDTH-bit operands over a valid/ready handshake and processes DIGIT bits per cycle through a registered carry. It returns the sum/difference with carry, signed-overflow and zero flags. It sits between a pin-level operand interface and any downstream consumer that can apply backpressure.

## Interface
- WIDTH, 8: operand/result width in bits; WIDTH ≥ 2.
- DIGIT, 1: bits processed per cycle; WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- a  in  WIDTH  operand A; ignored when acc_sel=1.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B; sampled at accept.
- acc_sel  in  1  1 = use accumulator register as A; sampled at accept.
- clr  in  1  synchronous clear of the accumulator.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, registered.
- carry  out  1  add: unsigned carry-out; sub: NOT borrow (1 when A ≥ B unsigned).
- overflow  out  1  two's-complement signed overflow of the operation.
- zero  out  1  sum == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1 at a clock edge, the request is accepted and the block:
  - latches A (a, or the accumulator when acc_sel=1) into the A shift register;
  - latches b, or ~b when sub=1, into the B shift register;
  - initialises the carry FF to sub;
  - clears the digit counter and moves to RUN.
- RUN: each cycle adds the low DIGIT bits of A, B and the carry FF, as a DIGIT-bit ripple.
  - Both operand registers shift right by DIGIT.
  - The result digit shifts in at the MSB end of the result register.
  - The carry FF takes the digit carry-out.
  - Before the final digit, the carry into the MSB is captured for the overflow flag.
  - After the N-th digit: overflow = carry_into_msb XOR carry_out; sum, carry, overflow and zero are registered; state moves to DONE.
- DONE: out_valid=1. sum/carry/overflow/zero are stable while out_valid=1 && out_ready=0.
  - On out_ready=1, the accumulator is loaded with sum and the state returns to IDLE.
- clr:
  - clears the accumulator to 0 in any state;
  - if it coincides with the DONE handshake, clr wins and the accumulator becomes 0;
  - does not affect an operation in flight.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- in_valid while not in IDLE is ignored, and no request is queued.

## Timing
- Reset values:
  - state = IDLE, so in_ready=1 during and after reset;
  - out_valid=0, sum=0, carry=0, overflow=0, zero=0, accumulator=0.
- Accept at edge E0. RUN occupies edges E1..EN, and out_valid rises after edge EN: latency is N cycles from accept to out_valid.
- Output handshake at edge EH: out_valid falls and in_ready rises after EH. The next accept is possible at EH+1 at the earliest.
- Throughput: one result per N+2 cycles with no backpressure.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- rst asserted in any state aborts the operation: all registers return to reset values asynchronously, and no partial result is ever presented.

## Test plan
- WIDTH=8, DIGIT=1, add 0x0F+0x01, out_ready=1 → sum=0x10, carry=0, overflow=0, zero=0; out_valid rises exactly 8 cycles after accept.
- Add 0xFF+0x01 → sum=0x00, carry=1, zero=1, overflow=0. Add 0x7F+0x01 → sum=0x80, overflow=1, carry=0.
- sub=1, 0x05−0x07 → sum=0xFE, carry=0, overflow=0. Then 0x80−0x01 → sum=0x7F, carry=1, overflow=1.
- Pulse clr, then three requests with acc_sel=1, b=0x10 → sums 0x10, 0x20, 0x30. Then clr coincident with the third handshake → the next acc_sel request with b=0x01 returns 0x01.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/flags stable and in_ready=0; in_valid pulses during RUN/DONE are dropped, so exactly one result is produced.
- Assert rst mid-RUN (digit 3) → out_valid=0, sum=0, accumulator=0 immediately, in_ready=1. Repeat the first scenario with DIGIT=4 → latency 2 cycles, identical results.
